clint_mmio: RTL and testbench

Memory-mapped core-local timer for the NPC core. It holds `mtime`, `mtimecmp` and `msip` behind a single-outstanding valid/ready load/store port on the LSU side. It drives the registered machine-timer interrupt request and software interrupt into the CSR file. It gates the timer interrupt with `mstatus.MIE`, `mie.MTIE` and the pipeline's interrupt-accept enable, all supplied by the CSR file and pipeline.

---
 rtl/clint_pkg.sv | 26 ++
 rtl/clint_mmio_if.sv | 26 ++
 rtl/clint_prescaler.sv | 26 ++
 rtl/clint_mmio.sv | 120 ++++++++++++
 tb/tb_clint_mmio.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clint_pkg.sv
// Shared constants and types for the core-local interruptor (timer + software interrupt).
package clint_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned STRB_W = XLEN / 8;

  localparam logic [XLEN-1:0] CLINT_MSIP_OFF     = 64'h0000_0000_0000_0000;
  localparam logic [XLEN-1:0] CLINT_MTIMECMP_OFF = 64'h0000_0000_0000_4000;
  localparam logic [XLEN-1:0] CLINT_MTIME_OFF    = 64'h0000_0000_0000_BFF8;

  localparam logic [XLEN-1:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

  // Machine timer interrupt cause, also consumed by the CSR file.
  localparam logic [XLEN-1:0] MCAUSE_MTI = 64'h8000_0000_0000_0007;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } req_state_e;

  typedef struct packed {
    logic [XLEN-1:0] rdata;
    logic            err;
  } clint_resp_t;

endpackage

// File: rtl/clint_mmio_if.sv
// LSU-side load/store port of the CLINT: one request outstanding, valid/ready on both legs.
interface clint_mmio_if;
  import clint_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/clint_prescaler.sv
// mtime prescaler: tick_c pulses once every TICK_DIV clocks; clr restarts the period.
module clint_prescaler #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;

  assign tick_c = (div_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst || clr || tick_c) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clint_mmio.sv
// Memory-mapped mtime/mtimecmp/msip block with registered timer interrupt request.
module clint_mmio
  import clint_pkg::*;
#(
  parameter logic [XLEN-1:0] BASE     = 64'h0000_0000_0200_0000,
  parameter int unsigned     TICK_DIV = 1
) (
  input  logic         clk,
  input  logic         rst,
  clint_mmio_if.slave  bus,
  input  logic         ena,
  input  logic         MIE,
  input  logic         MTIE,
  output logic         tint,
  output logic         msip
);

  req_state_e      state, state_nxt;
  logic            accept_c;
  logic [XLEN-1:0] mtime, mtimecmp;
  logic            msip_q;
  logic [XLEN-1:0] off_c, rd_c;
  logic            aligned_c, sel_msip_c, sel_cmp_c, sel_time_c, hit_c;
  logic            mtime_wr_c, tick_c, mtip_c;
  clint_resp_t     resp_q, resp_nxt;

  function automatic logic [XLEN-1:0] strb_merge(input logic [XLEN-1:0]   old_v,
                                                 input logic [XLEN-1:0]   new_v,
                                                 input logic [STRB_W-1:0] strb);
    logic [XLEN-1:0] res;
    res = old_v;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Request FSM: a new request is taken only while no response is pending.
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept_c  = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = (state == ST_RESP);
  assign bus.resp_rdata = resp_q.rdata;
  assign bus.resp_err   = resp_q.err;
  assign msip           = msip_q;

  // Address decode and load mux on pre-edge register values.
  always_comb begin
    off_c      = bus.req_addr - BASE;
    aligned_c  = (bus.req_addr[2:0] == 3'b000);
    sel_msip_c = aligned_c && (off_c == CLINT_MSIP_OFF);
    sel_cmp_c  = aligned_c && (off_c == CLINT_MTIMECMP_OFF);
    sel_time_c = aligned_c && (off_c == CLINT_MTIME_OFF);
    hit_c      = sel_msip_c || sel_cmp_c || sel_time_c;
    rd_c       = '0;
    if (sel_msip_c)      rd_c = XLEN'(msip_q);
    else if (sel_cmp_c)  rd_c = mtimecmp;
    else if (sel_time_c) rd_c = mtime;
    resp_nxt.err   = ~hit_c;
    resp_nxt.rdata = bus.req_we ? '0 : rd_c;
  end

  assign mtime_wr_c = accept_c && bus.req_we && sel_time_c;
  assign mtip_c     = (mtime >= mtimecmp);

  clint_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clr    (mtime_wr_c),
    .tick_c (tick_c)
  );

  // A store to mtime overrides the increment due on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime    <= '0;
      mtimecmp <= MTIMECMP_RST;
      msip_q   <= 1'b0;
      resp_q   <= '0;
      tint     <= 1'b0;
    end else begin
      if (mtime_wr_c) begin
        mtime <= strb_merge(mtime, bus.req_wdata, bus.req_wstrb);
      end else if (tick_c) begin
        mtime <= mtime + XLEN'(1);
      end
      if (accept_c && bus.req_we && sel_cmp_c) begin
        mtimecmp <= strb_merge(mtimecmp, bus.req_wdata, bus.req_wstrb);
      end
      if (accept_c && bus.req_we && sel_msip_c && bus.req_wstrb[0]) begin
        msip_q <= bus.req_wdata[0];
      end
      if (accept_c) resp_q <= resp_nxt;
      tint <= mtip_c & MIE & MTIE & ena;
    end
  end

endmodule

// File: tb/tb_clint_mmio.sv
// Drives two CLINTs (TICK_DIV 1 and 4) with identical traffic and checks them against a timeline model.
module tb_clint_mmio;
  import clint_pkg::*;

  localparam logic [63:0] BASE   = 64'h0000_0000_0200_0000;
  localparam logic [63:0] A_MSIP = BASE;
  localparam logic [63:0] A_CMP  = BASE + 64'h4000;
  localparam logic [63:0] A_TIME = BASE + 64'hBFF8;
  localparam int unsigned DIV_A  = 1;
  localparam int unsigned DIV_B  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b0, mie = 1'b0, mtie = 1'b0;
  logic tint_a, tint_b, msip_a, msip_b;

  clint_mmio_if ifa ();
  clint_mmio_if ifb ();

  clint_mmio #(.BASE(BASE), .TICK_DIV(DIV_A)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa), .ena(ena), .MIE(mie), .MTIE(mtie),
    .tint(tint_a), .msip(msip_a)
  );

  clint_mmio #(.BASE(BASE), .TICK_DIV(DIV_B)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb), .ena(ena), .MIE(mie), .MTIE(mtie),
    .tint(tint_b), .msip(msip_b)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] o_rd[2];
  logic        o_er[2], o_rv[2], o_rr[2], o_tint[2], o_msip[2];
  assign o_rd[0] = ifa.resp_rdata;  assign o_rd[1] = ifb.resp_rdata;
  assign o_er[0] = ifa.resp_err;    assign o_er[1] = ifb.resp_err;
  assign o_rv[0] = ifa.resp_valid;  assign o_rv[1] = ifb.resp_valid;
  assign o_rr[0] = ifa.req_ready;   assign o_rr[1] = ifb.req_ready;
  assign o_tint[0] = tint_a;        assign o_tint[1] = tint_b;
  assign o_msip[0] = msip_a;        assign o_msip[1] = msip_b;

  int n_vec = 0;
  int n_err = 0;

  // mtime(c) = base + (c - base_c) / div, re-anchored on reset and on every mtime store.
  logic [63:0] m_base[2];
  longint      m_base_c[2];
  logic [63:0] m_cmp[2];
  logic        m_msip[2];
  logic        exp_tint[2];
  logic [63:0] exp_rd[2];
  logic        exp_er[2];
  logic        exp_busy = 1'b0;
  logic        mon_on = 1'b0;

  function automatic logic [63:0] mt(input int d, input longint c);
    longint dv;
    dv = (d == 0) ? longint'(DIV_A) : longint'(DIV_B);
    return m_base[d] + 64'((c - m_base_c[d]) / dv);
  endfunction

  function automatic logic [63:0] bmerge(input logic [63:0] o, input logic [63:0] w,
                                         input logic [7:0] s);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) if (s[i]) m = m | (64'hFF << (8 * i));
    return (o & ~m) | (w & m);
  endfunction

  task automatic check(input string tag, input int d, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d: got %h expected %h", tag, d, got, exp);
    end
  endtask

  task automatic check1(input string tag, input int d, input logic got, input logic exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d: got %b expected %b", tag, d, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [63:0] a,
                       input logic [63:0] wd, input logic [7:0] ws);
    ifa.req_valid = v; ifa.req_we = we; ifa.req_addr = a; ifa.req_wdata = wd; ifa.req_wstrb = ws;
    ifb.req_valid = v; ifb.req_we = we; ifb.req_addr = a; ifb.req_wdata = wd; ifb.req_wstrb = ws;
  endtask

  task automatic set_resp_ready(input logic r);
    ifa.resp_ready = r;
    ifb.resp_ready = r;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      m_base[d]   = '0;
      m_base_c[d] = cyc;
      m_cmp[d]    = 64'hFFFF_FFFF_FFFF_FFFF;
      m_msip[d]   = 1'b0;
      exp_tint[d] = 1'b0;
    end
    exp_busy = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    mon_on = 1'b0;
    rst    = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    drive(1'b0, 1'b0, '0, '0, '0);
    set_resp_ready(1'b0);
    rst = 1'b0;
    reset_model();
    mon_on = 1'b1;
  endtask

  // Present one request, take it on the next edge and check the response.
  task automatic issue(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] wstrb);
    longint      n;
    logic [63:0] pre;
    logic        mapped;
    for (int d = 0; d < 2; d++) check1("req_ready_before", d, o_rr[d], 1'b1);
    drive(1'b1, we, addr, wdata, wstrb);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, '0, '0, '0);
    n = cyc;
    mapped = (addr[2:0] == 3'b000) && (addr == A_MSIP || addr == A_CMP || addr == A_TIME);
    for (int d = 0; d < 2; d++) begin
      pre       = mt(d, n - 1);
      exp_er[d] = !mapped;
      exp_rd[d] = '0;
      if (mapped && !we) begin
        if (addr == A_MSIP)     exp_rd[d] = {63'b0, m_msip[d]};
        else if (addr == A_CMP) exp_rd[d] = m_cmp[d];
        else                    exp_rd[d] = pre;
      end else if (mapped) begin
        if (addr == A_MSIP && wstrb[0]) m_msip[d] = wdata[0];
        if (addr == A_CMP) m_cmp[d] = bmerge(m_cmp[d], wdata, wstrb);
        if (addr == A_TIME) begin
          m_base[d]   = bmerge(pre, wdata, wstrb);
          m_base_c[d] = n;
        end
      end
    end
    exp_busy = 1'b1;
    for (int d = 0; d < 2; d++) begin
      check1("resp_valid", d, o_rv[d], 1'b1);
      check("resp_rdata", d, o_rd[d], exp_rd[d]);
      check1("resp_err", d, o_er[d], exp_er[d]);
    end
  endtask

  // Stall the response for 'hold' cycles, optionally with a competing request, then retire it.
  task automatic complete(input int hold, input logic bogus);
    if (bogus) drive(1'b1, 1'b1, A_MSIP, {63'b0, ~m_msip[0]}, 8'hFF);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        check("rdata_hold", d, o_rd[d], exp_rd[d]);
        check1("err_hold", d, o_er[d], exp_er[d]);
        check1("req_ready_hold", d, o_rr[d], 1'b0);
      end
    end
    set_resp_ready(1'b1);
    @(posedge clk); #1;
    set_resp_ready(1'b0);
    drive(1'b0, 1'b0, '0, '0, '0);
    exp_busy = 1'b0;
    for (int d = 0; d < 2; d++) check1("resp_retired", d, o_rv[d], 1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      for (int d = 0; d < 2; d++) begin
        check1("tint", d, o_tint[d], exp_tint[d]);
        check1("msip_out", d, o_msip[d], m_msip[d]);
        check1("resp_valid_mon", d, o_rv[d], exp_busy);
        check1("req_ready_mon", d, o_rr[d], !exp_busy);
        exp_tint[d] = (mt(d, cyc) >= m_cmp[d]) && mie && mtie && ena;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] a, wd;
    logic [7:0]  ws;
    logic        we;
    int          kind;

    drive(1'b0, 1'b0, '0, '0, '0);
    set_resp_ready(1'b0);
    do_reset(3);

    // Free-running mtime after reset, plus reset values of the other registers.
    idle(10);
    issue(1'b0, A_TIME, '0, '0);
    check1("mtime_10_or_11", 0, (o_rd[0] == 64'd10) || (o_rd[0] == 64'd11), 1'b1);
    complete(0, 1'b0);
    issue(1'b0, A_CMP, '0, '0);   complete(0, 1'b0);
    issue(1'b0, A_MSIP, '0, '0);  complete(0, 1'b0);

    // Timer interrupt raised at mtimecmp=20, then withdrawn by raising mtimecmp.
    mie = 1'b1; mtie = 1'b1; ena = 1'b1;
    issue(1'b1, A_CMP, 64'd20, 8'hFF);  complete(0, 1'b0);
    while (mt(0, cyc) < 64'd26) idle(1);
    issue(1'b1, A_CMP, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);  complete(0, 1'b0);
    idle(3);

    // Wrap of mtime with mtimecmp=0 keeps the interrupt pending.
    issue(1'b1, A_CMP, 64'd0, 8'hFF);  complete(0, 1'b0);
    issue(1'b1, A_TIME, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);  complete(0, 1'b0);
    idle(1);
    issue(1'b0, A_TIME, '0, '0);  complete(0, 1'b0);
    idle(8);
    issue(1'b0, A_TIME, '0, '0);  complete(0, 1'b0);

    // mtime store landing on the edge where the divide-by-4 tick is due.
    while ((((cyc + 1) - m_base_c[1]) % 4) != 0) idle(1);
    issue(1'b1, A_TIME, 64'd0, 8'hFF);  complete(0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      issue(1'b0, A_TIME, '0, '0);  complete(k % 2, 1'b0);
    end
    issue(1'b1, A_TIME, 64'h1122_3344_5566_7788, 8'h0F);  complete(0, 1'b0);
    issue(1'b0, A_TIME, '0, '0);  complete(0, 1'b0);

    // Unmapped and misaligned accesses, response stalled with a competing request.
    issue(1'b0, BASE + 64'h8, '0, '0);     complete(3, 1'b1);
    issue(1'b0, BASE + 64'h4004, '0, '0);  complete(3, 1'b1);
    issue(1'b1, BASE + 64'h8, 64'hDEAD_BEEF, 8'hFF);     complete(1, 1'b0);
    issue(1'b1, BASE + 64'hBFFC, 64'hDEAD_BEEF, 8'hFF);  complete(0, 1'b0);
    issue(1'b1, BASE + 64'h4001, 64'h5, 8'hFF);          complete(0, 1'b0);
    issue(1'b0, A_CMP, '0, '0);   complete(0, 1'b0);
    issue(1'b0, A_TIME, '0, '0);  complete(0, 1'b0);

    // Software interrupt bit.
    issue(1'b1, A_MSIP, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01);  complete(0, 1'b0);
    issue(1'b0, A_MSIP, '0, '0);
    check("msip_load_one", 0, o_rd[0], 64'h1);
    complete(0, 1'b0);
    issue(1'b1, A_MSIP, 64'h0, 8'hFE);  complete(0, 1'b0);
    issue(1'b0, A_MSIP, '0, '0);        complete(0, 1'b0);

    // Reset with a response pending, and reset on an edge that would accept a request.
    issue(1'b0, A_TIME, '0, '0);
    do_reset(1);
    idle(2);
    drive(1'b1, 1'b1, A_MSIP, 64'h1, 8'hFF);
    do_reset(2);
    idle(3);
    issue(1'b0, A_MSIP, '0, '0);  complete(0, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 150; i++) begin
      idle($urandom_range(0, 3));
      mie  = ($urandom_range(0, 3) != 0);
      mtie = ($urandom_range(0, 3) != 0);
      ena  = ($urandom_range(0, 3) != 0);
      kind = $urandom_range(0, 7);
      case (kind)
        0:       a = A_MSIP;
        1, 2:    a = A_CMP;
        3, 7:    a = A_TIME;
        4:       a = A_CMP + 64'($urandom_range(1, 7));
        5:       a = BASE + 64'(16'($urandom) & 16'hFFF8);
        default: a = {$urandom, $urandom};
      endcase
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) wd = mt(0, cyc) + 64'($urandom_range(0, 30));
      else                           wd = {$urandom, $urandom};
      ws = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      issue(we, a, wd, ws);
      complete($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
